// File: rtl/gsim_residual_chk.sv
// gsim_residual_chk
// In-system checker for the GSIM solver. It snoops the b-vector going into
// the solver and the x-vector coming out of it. It recomputes M*x for the
// fixed 16x16 banded matrix (diagonal 20, off-diagonals -13, 6, -1) in
// Q16.16, emits one residual err = M*x - b per row, tracks max |err| and
// flags pass/done for the frame.
//
// Optional feature macro: GSIM_CHK_SUMABS_EN. When defined, it adds the
// sum_abs_err output and the SUM_TOL parameter, and pass then also
// requires sum_abs_err <= SUM_TOL.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   in_en         b word valid (same strobe that feeds GSIM)
//   b_in[15:0]    b word, signed integer
//   out_valid     x word valid (from GSIM)
//   x_out[31:0]   x word, signed Q16.16
//   res_valid     one-cycle strobe, res_idx/res_err valid
//   res_idx[3:0]  row of the current residual
//   res_err[39:0] signed Q16.16 residual of row res_idx
//   max_abs_err   running max |res_err| of the current frame
//   done          level, all 16 residuals emitted
//   pass          level, valid while done: max_abs_err <= TOL
//   protocol_err  sticky, a word arrived that did not fit the frame
//   sum_abs_err   (GSIM_CHK_SUMABS_EN only) sum of |res_err| over the frame
module gsim_residual_chk #(
    parameter int          N   = 16,
    parameter logic [39:0] TOL = 40'd16
`ifdef GSIM_CHK_SUMABS_EN
    ,
    parameter logic [43:0] SUM_TOL = 44'd128
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    input  logic        out_valid,
    input  logic [31:0] x_out,
    output logic        res_valid,
    output logic [3:0]  res_idx,
    output logic [39:0] res_err,
    output logic [39:0] max_abs_err,
    output logic        done,
    output logic        pass,
    output logic        protocol_err
`ifdef GSIM_CHK_SUMABS_EN
    ,
    output logic [43:0] sum_abs_err
`endif
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [4:0] FULL = 5'(N);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [4:0]         b_cnt_r;
    logic [4:0]         x_cnt_r;
    logic [3:0]         row_r;
    logic [15:0]        b_mem_r [16];
    logic [31:0]        x_mem_r [16];

    logic               b_we_s;
    logic               x_we_s;
    logic [3:0]         b_waddr_s;
    logic [3:0]         x_waddr_s;
    logic               perr_set_s;
    logic               new_frame_s;

    int                 tap_s;
    logic signed [39:0] mb_s;
    logic signed [39:0] b_term_s;
    logic signed [39:0] err_s;
    logic [39:0]        abs_err_s;
    logic [39:0]        max_nxt_s;
    logic               pass_ok_s;

    logic               res_valid_r;
    logic [3:0]         res_idx_r;
    logic [39:0]        res_err_r;
    logic [39:0]        max_abs_err_r;
    logic               done_r;
    logic               pass_r;
    logic               protocol_err_r;

    // Band coefficient c(k) for tap offset k = -3..+3.
    function automatic logic signed [39:0] coef(input int k);
        case (k)
            0:       coef = 40'sd20;
            1, -1:   coef = -40'sd13;
            2, -2:   coef = 40'sd6;
            3, -3:   coef = -40'sd1;
            default: coef = 40'sd0;
        endcase
    endfunction

    // Sign-extend a Q16.16 x word to the 40-bit accumulator width.
    function automatic logic signed [39:0] sext_x(input logic [31:0] v);
        return {{8{v[31]}}, v};
    endfunction

    // FSM next state plus buffer write enables and protocol error detection.
    always_comb begin
        state_nxt_s = state_r;
        b_we_s      = 1'b0;
        x_we_s      = 1'b0;
        b_waddr_s   = b_cnt_r[3:0];
        x_waddr_s   = x_cnt_r[3:0];
        perr_set_s  = 1'b0;
        new_frame_s = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (in_en) begin
                    if (b_cnt_r < FULL) begin
                        b_we_s = 1'b1;
                    end else begin
                        perr_set_s = 1'b1;
                    end
                end else begin
                    b_we_s = 1'b0;
                end
                if (out_valid) begin
                    if (x_cnt_r < FULL) begin
                        x_we_s = 1'b1;
                    end else begin
                        perr_set_s = 1'b1;
                    end
                end else begin
                    x_we_s = 1'b0;
                end
                if ((b_cnt_r == FULL) && (x_cnt_r == FULL)) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_CALC: begin
                if (in_en || out_valid) begin
                    perr_set_s = 1'b1;
                end else begin
                    perr_set_s = 1'b0;
                end
                if (row_r == 4'd15) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                // A b word opens the next frame; a lone x word cannot.
                if (in_en) begin
                    new_frame_s = 1'b1;
                    b_we_s      = 1'b1;
                    b_waddr_s   = 4'd0;
                    x_we_s      = out_valid;
                    x_waddr_s   = 4'd0;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    perr_set_s  = out_valid;
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_COLLECT;
            end
        endcase
    end

    // Banded row product, residual and its magnitude for row row_r.
    always_comb begin
        mb_s  = 40'sd0;
        tap_s = 0;
        for (int k = -3; k <= 3; k++) begin
            tap_s = int'(row_r) + k;
            mb_s  = mb_s + (((tap_s >= 0) && (tap_s < N)) ?
                            coef(k) * sext_x(x_mem_r[tap_s[3:0]]) : 40'sd0);
        end
        b_term_s  = {{8{b_mem_r[row_r][15]}}, b_mem_r[row_r], 16'h0000};
        err_s     = mb_s - b_term_s;
        abs_err_s = err_s[39] ? (40'd0 - err_s) : err_s;
        max_nxt_s = (abs_err_s > max_abs_err_r) ? abs_err_s : max_abs_err_r;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Vector buffers; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (b_we_s) begin
            b_mem_r[b_waddr_s] <= b_in;
        end
        if (x_we_s) begin
            x_mem_r[x_waddr_s] <= x_out;
        end
    end

    // Arrival counters, restarted when a new frame opens from DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_cnt_r <= 5'd0;
            x_cnt_r <= 5'd0;
        end else if (new_frame_s) begin
            b_cnt_r <= 5'd1;
            x_cnt_r <= out_valid ? 5'd1 : 5'd0;
        end else begin
            b_cnt_r <= b_cnt_r + {4'd0, b_we_s};
            x_cnt_r <= x_cnt_r + {4'd0, x_we_s};
        end
    end

    // Residual outputs, row sequencing and frame status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r          <= 4'd0;
            res_valid_r    <= 1'b0;
            res_idx_r      <= 4'd0;
            res_err_r      <= 40'd0;
            max_abs_err_r  <= 40'd0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            protocol_err_r <= 1'b0;
        end else begin
            if (perr_set_s) begin
                protocol_err_r <= 1'b1;
            end
            case (state_r)
                ST_COLLECT: begin
                    res_valid_r <= 1'b0;
                    row_r       <= 4'd0;
                end
                ST_CALC: begin
                    res_valid_r   <= 1'b1;
                    res_idx_r     <= row_r;
                    res_err_r     <= err_s;
                    max_abs_err_r <= max_nxt_s;
                    row_r         <= row_r + 4'd1;
                end
                ST_DONE: begin
                    res_valid_r <= 1'b0;
                    if (new_frame_s) begin
                        done_r        <= 1'b0;
                        pass_r        <= 1'b0;
                        max_abs_err_r <= 40'd0;
                    end else begin
                        done_r <= 1'b1;
                        pass_r <= pass_ok_s;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef GSIM_CHK_SUMABS_EN
    logic [43:0] sum_abs_err_r;

    // Frame sum of |err|, cleared alongside max_abs_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_abs_err_r <= 44'd0;
        end else if (new_frame_s) begin
            sum_abs_err_r <= 44'd0;
        end else if (state_r == ST_CALC) begin
            sum_abs_err_r <= sum_abs_err_r + {4'd0, abs_err_s};
        end else begin
            sum_abs_err_r <= sum_abs_err_r;
        end
    end

    assign pass_ok_s   = (max_abs_err_r <= TOL) && (sum_abs_err_r <= SUM_TOL);
    assign sum_abs_err = sum_abs_err_r;
`else
    assign pass_ok_s   = (max_abs_err_r <= TOL);
`endif

    assign res_valid    = res_valid_r;
    assign res_idx      = res_idx_r;
    assign res_err      = res_err_r;
    assign max_abs_err  = max_abs_err_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign protocol_err = protocol_err_r;

endmodule

// File: tb/tb_gsim_residual_chk.sv
module tb_gsim_residual_chk;

    logic        clk;
    logic        reset;
    logic        in_en;
    logic [15:0] b_in;
    logic        out_valid;
    logic [31:0] x_out;
    logic        res_valid;
    logic [3:0]  res_idx;
    logic [39:0] res_err;
    logic [39:0] max_abs_err;
    logic        done;
    logic        pass;
    logic        protocol_err;
`ifdef GSIM_CHK_SUMABS_EN
    logic [43:0] sum_abs_err;
`endif

    gsim_residual_chk dut (
        .clk          (clk),
        .reset        (reset),
        .in_en        (in_en),
        .b_in         (b_in),
        .out_valid    (out_valid),
        .x_out        (x_out),
        .res_valid    (res_valid),
        .res_idx      (res_idx),
        .res_err      (res_err),
        .max_abs_err  (max_abs_err),
        .done         (done),
        .pass         (pass),
        .protocol_err (protocol_err)
`ifdef GSIM_CHK_SUMABS_EN
        ,
        .sum_abs_err  (sum_abs_err)
`endif
    );

    typedef struct {
        logic [3:0]  idx;
        logic [39:0] err;
        logic [39:0] mx;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cap = 0;
    int   strobe_cnt = 0;

    localparam logic [31:0] X_POS   = 32'h0001_0000;
    localparam logic [31:0] X_NEG   = 32'hFFFF_0000;
    localparam logic [39:0] ERR_M1  = 40'hFF_FFFF_0000;
    localparam logic [39:0] ONE_Q16 = 40'h00_0001_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // b pattern: sel 0 = base, 1 = base with b[7]=5, 2 = base negated
    function automatic logic [15:0] b_word(input int sel, input int i);
        logic signed [15:0] base [16];
        logic signed [15:0] w;
        base = '{16'sd12, -16'sd1, 16'sd5, 16'sd4, 16'sd4, 16'sd4, 16'sd4, 16'sd4,
                 16'sd4, 16'sd4, 16'sd4, 16'sd4, 16'sd4, 16'sd5, -16'sd1, 16'sd12};
        w = base[i];
        if (sel == 1 && i == 7) w = 16'sd5;
        if (sel == 2) w = -w;
        return w;
    endfunction

    // Monitor: pop and compare on every residual strobe.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_res_valid", {63'd0, res_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_idx", {60'd0, res_idx}, {60'd0, e.idx});
                chk("res_err", {24'd0, res_err}, {24'd0, e.err});
                chk("max_abs_err", {24'd0, max_abs_err}, {24'd0, e.mx});
                if (e.idx == 4'd0) begin
                    chk("first_res_latency", 64'(cyc - last_cap), 64'd2);
                end
            end
            strobe_cnt = strobe_cnt + 1;
        end
    end

    // One cycle of input drive; returns 1 time unit after the capturing edge.
    task automatic drive(input logic ie, input logic [15:0] b, input logic ov, input logic [31:0] x);
        in_en = ie; b_in = b; out_valid = ov; x_out = x;
        @(posedge clk); #1;
        in_en = 1'b0; out_valid = 1'b0;
    endtask

    // mode 0: b and x together; 1: all x then all b; 2: all b (opt. 17th) then x
    task automatic send_frame(input int sel, input logic [31:0] xv, input int mode,
                              input bit extra, input bit chk_clear);
        for (int r = 0; r < 16; r++) begin
            exp_t e;
            e.idx = 4'(r);
            e.err = (sel == 1 && r == 7) ? ERR_M1 : 40'd0;
            e.mx  = (sel == 1 && r >= 7) ? ONE_Q16 : 40'd0;
            sb.push_back(e);
        end
        if (mode == 0) begin
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, b_word(sel, i), 1'b1, xv);
                if (i == 0 && chk_clear) begin
                    chk("done_clear", {63'd0, done}, 64'd0);
                    chk("max_clear", {24'd0, max_abs_err}, 64'd0);
                end
            end
        end else if (mode == 1) begin
            for (int i = 0; i < 16; i++) drive(1'b0, 16'd0, 1'b1, xv);
            for (int i = 0; i < 16; i++) drive(1'b1, b_word(sel, i), 1'b0, 32'd0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, b_word(sel, i), 1'b0, 32'd0);
                if (i == 0 && chk_clear) begin
                    chk("done_clear", {63'd0, done}, 64'd0);
                    chk("max_clear", {24'd0, max_abs_err}, 64'd0);
                end
            end
            if (extra) drive(1'b1, 16'd99, 1'b0, 32'd0);
            for (int i = 0; i < 16; i++) drive(1'b0, 16'd0, 1'b1, xv);
        end
        last_cap = cyc;
    endtask

    task automatic wait_done(input logic exp_pass, input logic [39:0] exp_max, input logic exp_perr);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done", {63'd0, done}, 64'd1);
        chk("pass", {63'd0, pass}, {63'd0, exp_pass});
        chk("final_max", {24'd0, max_abs_err}, {24'd0, exp_max});
        chk("protocol_err", {63'd0, protocol_err}, {63'd0, exp_perr});
        chk("res_valid_in_done", {63'd0, res_valid}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int target;
        int n;
        reset = 1'b0; in_en = 1'b0; out_valid = 1'b0; b_in = 16'd0; x_out = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_perr", {63'd0, protocol_err}, 64'd0);
        chk("rst_max", {24'd0, max_abs_err}, 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 1: all-ones x, x arrives before b
        send_frame(0, X_POS, 1, 1'b0, 1'b0);
        wait_done(1'b1, 40'd0, 1'b0);

        // 2: b[7]=5, starts while done=1
        send_frame(1, X_POS, 0, 1'b0, 1'b1);
        wait_done(1'b0, ONE_Q16, 1'b0);

        // 3: negative x and b, starts while done=1 with nonzero max
        send_frame(2, X_NEG, 2, 1'b0, 1'b1);
        wait_done(1'b1, 40'd0, 1'b0);

        // 4: 17 in_en pulses
        send_frame(0, X_POS, 2, 1'b1, 1'b0);
        wait_done(1'b1, 40'd0, 1'b1);

        // 5: reset at the 5th residual strobe
        send_frame(0, X_POS, 0, 1'b0, 1'b0);
        target = strobe_cnt + 5;
        n = 0;
        while (strobe_cnt < target && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("fifth_strobe_seen", 64'(strobe_cnt), 64'(target));
        #1 reset = 1'b0;
        #1;
        chk("midrst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("midrst_res_err", {24'd0, res_err}, 64'd0);
        chk("midrst_res_idx", {60'd0, res_idx}, 64'd0);
        chk("midrst_max", {24'd0, max_abs_err}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_perr", {63'd0, protocol_err}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send_frame(0, X_POS, 1, 1'b0, 1'b0);
        wait_done(1'b1, 40'd0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gsim_residual_chk.md
Name: gsim_residual_chk

Overview:
- Hardware consumer that sits on the GSIM solver interface and checks it in-system.
- Snoops the b-vector stream going into GSIM and the x-vector stream coming out.
- Recomputes M·x for the 16x16 banded matrix (diagonal 20, off-diagonals -13, 6, -1) in Q16.16 and emits a per-row residual err = M·x − b.
- Tracks max |err| and raises pass/done, replacing the software checker for silicon and FPGA bring-up.

Parameters:
- N, 16, vector length. Fixed at 16; not otherwise supported.
- TOL, 40'd16, pass threshold on max |err|, in Q16.16 LSBs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_en  in  1  b word valid (the same in_en that drives GSIM).
- b_in  in  16  b word, signed integer, two's complement.
- out_valid  in  1  x word valid (from GSIM).
- x_out  in  32  x word, signed Q16.16.
- res_valid  out  1  one-cycle strobe: res_idx/res_err valid.
- res_idx  out  4  row index of current residual.
- res_err  out  40  signed Q16.16 residual for row res_idx.
- max_abs_err  out  40  running max |res_err| of the current frame.
- done  out  1  level: all 16 residuals emitted.
- pass  out  1  level, valid while done=1: max_abs_err <= TOL.
- protocol_err  out  1  sticky: word received beyond 16 in a frame.

Behaviour:
- Reset (reset=0, async): all outputs 0, counters 0, state COLLECT. Buffers need not be cleared.
- Storage: b_mem[16] x 16b and x_mem[16] x 32b, written in arrival order.
  - b_cnt and x_cnt (0..16) advance independently.
  - in_en and out_valid in the same cycle: both words captured.
  - x may arrive before b completes.
- COLLECT:
  - in_en with b_cnt<16: store b, b_cnt++.
  - in_en with b_cnt==16: word dropped, protocol_err<=1. Same rule for out_valid/x_cnt.
  - Exit to CALC on the clock edge after both counters equal 16.
- CALC: row r = 0..15, one row per cycle, 16 cycles total.
  - Mb[r] = Σ c(k)·x[r+k] for k = −3..+3, with c(0)=20, c(±1)=−13, c(±2)=6, c(±3)=−1.
  - Terms with r+k outside 0..15 are omitted.
  - err = Mb[r] − sign_ext(b[r])<<16.
  - All arithmetic is signed, sign-extended to 40 bits. No saturation; 40 bits cannot overflow.
  - Registered output: res_valid=1, res_idx=r, res_err=err in the cycle after row r is computed.
  - First res_valid is 2 cycles after the edge at which the last word is captured.
  - max_abs_err <= max(max_abs_err, |err|), updated in the same cycle as res_err.
- DONE:
  - Entered after row 15 is emitted. done=1 and pass are held; res_valid=0.
  - The next in_en starts a new frame: that word is stored as b[0], b_cnt=1, x_cnt=0, done/pass/max_abs_err cleared, state COLLECT.
- in_en or out_valid during CALC: word dropped, protocol_err<=1.
- protocol_err clears only on reset.
- Reset asserted mid-CALC: outputs drop to 0 immediately (async); no residual is emitted after reset release until a full new frame is collected.

Optional Feature:
- GSIM_CHK_SUMABS_EN defined:
  - Adds output sum_abs_err [43:0] = Σ|res_err| over the frame, reset/cleared like max_abs_err.
  - Adds parameter SUM_TOL (default 44'd128).
  - pass additionally requires sum_abs_err <= SUM_TOL.
- Undefined: no port, no parameter, no logic; pass depends on max_abs_err only.

Test Plan:
- x all 0x00010000 (1.0); b = 12,−1,5,4,4,4,4,4,4,4,4,4,4,5,−1,12 -> 16 res_valid strobes with idx 0..15, all res_err=0, max_abs_err=0, done=1, pass=1.
- Same frame but b[7]=5 -> row 7 res_err=−0x10000 (40-bit two's complement), other rows 0, max_abs_err=0x10000, pass=0.
- All x 0xFFFF0000 (−1.0) with b negated (b[0]=0xFFF4 etc.) -> all res_err=0, pass=1. Checks sign extension of b and x.
- 17 in_en pulses in one frame -> protocol_err=1, 17th word ignored, residuals identical to the first test.
- reset driven low at 5th res_valid -> outputs 0 immediately. After release and a full valid frame -> clean 16 residuals, protocol_err=0.
- Back-to-back frames: second frame's first in_en arrives while done=1 -> done and max_abs_err clear that cycle, second frame is checked independently.
